// File: rtl/mont_mult_if.sv
// Request/response bundle for mont_mult: operands and modulus in, busy/done/result out.
interface mont_mult_if #(
  parameter int unsigned WIDTH = 2048,
  parameter int unsigned LEN_W = 12
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] n;
  logic [LEN_W-1:0] n_len;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, a, b, n, n_len,
    input  busy, done, result
  );

  modport slave (
    input  start, a, b, n, n_len,
    output busy, done, result
  );
endinterface

// File: rtl/mont_mult.sv
// Bit-serial radix-2 Montgomery multiplier: result = a * b * 2^-len mod n, one bit of a per clock.
// Define MONT_MULT_FINAL_SUB_EN to fully reduce the result below n; otherwise result < 2n.
module mont_mult #(
  parameter int unsigned WIDTH = 2048,
  parameter int unsigned LEN_W = 12
) (
  input logic        clk,
  input logic        rst,
  mont_mult_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoop, StFinal, StDone} state_e;

  localparam logic [LEN_W-1:0] WidthLen = LEN_W'(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   n_q, n_d;
  logic [WIDTH+1:0]   s_q, s_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic [LEN_W-1:0]   len_clamped;
  logic [WIDTH+1:0]   n_ext;
  logic [WIDTH+1:0]   t_add;
  logic [WIDTH+1:0]   t_red;
  logic [WIDTH+1:0]   s_shift;
  logic [WIDTH-1:0]   s_final;

  assign len_clamped = (bus.n_len > WidthLen) ? WidthLen : bus.n_len;
  assign n_ext       = {2'b00, n_q};

  // S < 2n keeps S + b + n below 4n, so WIDTH+2 bits never overflow.
  assign t_add   = s_q + (a_q[0] ? {2'b00, b_q} : '0);
  assign t_red   = t_add[0] ? (t_add + n_ext) : t_add;
  assign s_shift = {1'b0, t_red[WIDTH+1:1]};

`ifdef MONT_MULT_FINAL_SUB_EN
  assign s_final = WIDTH'((s_q >= n_ext) ? (s_q - n_ext) : s_q);
`else
  assign s_final = s_q[WIDTH-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          n_d     = bus.n;
          len_d   = len_clamped;
          s_d     = '0;
          cnt_d   = '0;
          state_d = (len_clamped == '0) ? StFinal : StLoop;
        end
      end
      StLoop: begin
        // a is consumed LSB first by shifting, so bit cnt is always a_q[0].
        s_d   = s_shift;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + LEN_W'(1);
        if (cnt_q == len_q - LEN_W'(1)) begin
          state_d = StFinal;
        end
      end
      StFinal: begin
        result_d = s_final;
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      s_q      <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == StLoop) || (state_q == StFinal);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;

endmodule

// File: tb/tb_mont_mult.sv
// Scoreboard bench for mont_mult: driver pushes REDC-model expectations, monitor checks on done.
module tb_mont_mult;
  localparam int unsigned W  = 16;
  localparam int unsigned LW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mont_mult_if #(.WIDTH(W), .LEN_W(LW)) mif ();

  mont_mult #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  typedef struct {
    logic [W-1:0] res;
    longint       acc;
    int           len;
  } exp_t;

  exp_t   exp_q[$];
  int     total    = 0;
  int     bad      = 0;
  int     done_cnt = 0;
  int     issued   = 0;
  longint cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clamp_len(input int nl);
    return (nl > int'(W)) ? int'(W) : nl;
  endfunction

  // Closed-form REDC: q = -ab/n mod R is the unique multiple making ab + qn divisible by R.
  function automatic logic [W-1:0] ref_mont(input longint unsigned a, input longint unsigned b,
                                            input longint unsigned n, input int nl);
    int              len;
    longint unsigned mask, inv, q, s;
    len = clamp_len(nl);
    if (len == 0) begin
      s = 64'd0;
    end else begin
      mask = (64'd1 << len) - 64'd1;
      inv  = n;
      repeat (5) inv = inv * (64'd2 - n * inv);
      q = (64'd0 - a * b * inv) & mask;
      s = (a * b + q * n) >> len;
    end
`ifdef MONT_MULT_FINAL_SUB_EN
    if (s >= n) s = s - n;
`endif
    return s[W-1:0];
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && mif.done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("result", mif.result, e.res);
          // done rises len+1 edges after the accepting edge (len+2 cycles counting that edge)
          check("latency", cyc - e.acc, e.len + 1);
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] n,
                       input int nl);
    mif.a     = a;
    mif.b     = b;
    mif.n     = n;
    mif.n_len = nl[LW-1:0];
    mif.start = 1'b1;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    exp_q.push_back('{res: ref_mont(a, b, n, nl), acc: cyc, len: clamp_len(nl)});
    issued++;
    check("busy_after_accept", mif.busy, 1);
    mif.a     = W'($urandom);
    mif.b     = W'($urandom);
    mif.n     = W'($urandom);
    mif.n_len = LW'($urandom);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (mif.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_within_budget", seen, 1);
    @(posedge clk);
    #1;
    check("done_single_cycle", mif.done, 0);
    check("idle_not_busy", mif.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned rn, ra, rb;
    int              nl, len;

    mif.start = 1'b0;
    mif.a     = '0;
    mif.b     = '0;
    mif.n     = '0;
    mif.n_len = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", mif.busy, 0);
    check("reset_done", mif.done, 0);
    check("reset_result", mif.result, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases; each start lands on the cycle after the previous done.
    issue(16'd7, 16'd9, 16'd13, 4);
    wait_done(20);
    issue(16'd11, 16'd12, 16'd13, 4);
    wait_done(20);
    issue(16'd2, 16'd1, 16'd13, 4);
    wait_done(20);
    issue(16'd7, 16'd9, 16'd13, 0);
    wait_done(20);

    // Start while busy must be ignored.
    issue(16'd7, 16'd9, 16'd13, 4);
    @(posedge clk);
    #1;
    mif.a     = 16'd1;
    mif.b     = 16'd1;
    mif.n     = 16'd13;
    mif.n_len = 5'd4;
    mif.start = 1'b1;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    check("busy_ignores_start", mif.busy, 1);
    wait_done(20);
    repeat (3) @(posedge clk);
    #1;
    check("one_done_per_op", done_cnt, issued);

    // Reset in the second LOOP cycle.
    issue(16'd11, 16'd12, 16'd13, 4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", mif.busy, 0);
    check("midrst_done", mif.done, 0);
    check("midrst_result", mif.result, 0);
    exp_q.delete();
    issued--;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("no_done_after_reset", done_cnt, issued);
    issue(16'd7, 16'd9, 16'd13, 4);
    wait_done(20);

    // n_len above WIDTH is clamped.
    rn = longint'(W'($urandom)) | 64'h8001;
    issue(W'(longint'($urandom) % rn), W'(longint'($urandom) % rn), W'(rn), 20);
    wait_done(40);

    for (int k = 0; k < 40; k++) begin
      nl  = $urandom_range(0, 18);
      len = clamp_len(nl);
      if (len == 0) begin
        rn = 64'd13;
        ra = 64'd7;
        rb = 64'd9;
      end else begin
        rn = (longint'($urandom) & ((64'd1 << len) - 64'd1)) | 64'd1;
        ra = longint'($urandom) % rn;
        rb = longint'($urandom) % rn;
      end
      issue(W'(ra), W'(rb), W'(rn), nl);
      wait_done(40);
    end

    check("done_count_final", done_cnt, issued);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mont_mult.md
# mont_mult

Bit-serial radix-2 Montgomery multiplier for the RSA datapath. It sits directly downstream of the Montgomery-form converter and consumes its output. It computes result = a · b · 2^(−n_len) mod n, using one operand bit per clock. Chained calls do modular exponentiation; a final call with b = 1 converts a value back out of Montgomery form.

## Interface
- WIDTH, 2048, operand and modulus width in bits
- LEN_W, 12, width of n_len; must hold the value WIDTH
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  multiplier operand, Montgomery form, a < n
- b  input  WIDTH  multiplicand operand, Montgomery form, b < n
- n  input  WIDTH  modulus; odd; n < 2^n_len
- n_len  input  LEN_W  modulus bit length; Montgomery radix R = 2^n_len
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; result is valid from this cycle
- result  output  WIDTH  product; held until the next accepted start

## Operation
- The FSM has four states: IDLE, LOOP, FINAL, DONE.
- IDLE, with start = 1:
  - Register a, b and n.
  - Set len = min(n_len, WIDTH), S = 0, cnt = 0.
  - Go to LOOP. If len == 0, go to FINAL instead.
- LOOP, one iteration per cycle, with a_i = bit cnt of the captured a:
  - T = S + (a_i ? b : 0).
  - If T[0] is 1, T = T + n.
  - S = T >> 1, then cnt = cnt + 1.
  - Go to FINAL when cnt == len − 1.
- Accumulator S is WIDTH+2 bits wide. Its invariant is S < 2n, so the sum never overflows.
- FINAL: result = (S ≥ n) ? S − n : S (see Configuration). Go to DONE.
- DONE: done = 1 for exactly one cycle, busy = 0. Go to IDLE.
- start while busy is ignored, and the captured operands are unaffected.
- Inputs a, b, n and n_len may change freely after acceptance.
- Behaviour is undefined for even n or for a, b ≥ n. No checking is done.

## Timing
- Reset values: busy = 0, done = 0, result = 0, state = IDLE, S = 0, cnt = 0.
- Latency is measured from the edge that samples start = 1 to the edge that raises done: len + 2 cycles.
  - len cycles of LOOP, 1 cycle of FINAL, then done.
  - The len == 0 case gives 2 cycles.
- busy is high during the LOOP and FINAL cycles. It is low in the DONE cycle.
- A new start is accepted on the cycle after done. Back-to-back throughput is len + 3 cycles per operation.
- An n_len larger than WIDTH is clamped to WIDTH.
- Reset asserted mid-operation:
  - All state returns to the reset values immediately.
  - No done pulse is emitted.
  - The previous result is lost (reads 0).

## Configuration
- MONT_MULT_FINAL_SUB_EN defined:
  - FINAL performs the conditional subtraction, so result < n.
  - A WIDTH+2-bit comparator and subtractor are instantiated.
- Not defined:
  - FINAL copies S[WIDTH-1:0] to result, giving result < 2n (lazy reduction).
  - Downstream must tolerate the redundant range.
  - Latency is unchanged. FINAL still takes one cycle.

## Test plan
- Basic, no reduction: WIDTH = 16, n = 13, n_len = 4, a = 7, b = 9, start → done after 6 cycles, result = 8.
- Final subtraction: n = 13, n_len = 4, a = 11, b = 12 → result = 5 with MONT_MULT_FINAL_SUB_EN, or 18 without it.
- Round trip out of Montgomery form: converter gives 5·16 mod 13 = 2. Then a = 2, b = 1 → result = 5.
- Degenerate length and back-to-back operation:
  - n_len = 0 → done after 2 cycles, result = 0.
  - A start pulsed on the cycle after done is accepted, and busy rises the next cycle.
- start while busy: during the first test's LOOP, pulse start with a = 1, b = 1 → ignored, result = 8, and exactly one done pulse.
- Reset mid-operation: assert rst at LOOP cycle 2 → busy = 0, done = 0 and result = 0 immediately. There is no done pulse later, and a fresh start after release completes normally.
